// File: rtl/boot_loader_if.sv
// Bus bundle between the boot copy engine and its ROM read port, RAM write port and CPU control.
// The engine uses the master modport; the ROM/RAM/CPU side uses the slave modport.
interface boot_loader_if;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_rddata;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wrdata;
    logic        ram_write;
    logic        ram_wait;
    logic        reload;
    logic        cpu_hold;
    logic        done;
    logic        sum_ok;

    modport master (
        output rom_addr,
        output ram_addr,
        output ram_wrdata,
        output ram_write,
        output cpu_hold,
        output done,
        output sum_ok,
        input  rom_rddata,
        input  ram_wait,
        input  reload
    );

    modport slave (
        input  rom_addr,
        input  ram_addr,
        input  ram_wrdata,
        input  ram_write,
        input  cpu_hold,
        input  done,
        input  sum_ok,
        output rom_rddata,
        output ram_wait,
        output reload
    );
endinterface

// File: rtl/boot_loader.sv
// Boot copy engine: copies LENGTH bytes of boot ROM into RAM at DEST_BASE while holding the CPU.
// Optional feature macro BOOT_CHECKSUM_EN adds an 8-bit image checksum reported on sum_ok.
module boot_loader #(
    parameter int          LENGTH    = 512,
    parameter logic [15:0] DEST_BASE = 16'hFE00
) (
    input logic          clk,
    input logic          rst,
    boot_loader_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [9:0] LAST_IDX = 10'(LENGTH - 1);

    state_e      state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [7:0]  wrdata_q, wrdata_d;
    logic        write_q, write_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;

    logic accept;
    logic last_byte;

    // A write retires only on an unstalled WRITE edge.
    assign accept    = (state_q == S_WRITE) && !bus.ram_wait;
    assign last_byte = (idx_q == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every flop sees pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_WRITE;
            S_WRITE: begin
                if (accept) begin
                    state_d = last_byte ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                if (bus.reload) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath/output next values.
    always_comb begin
        idx_d    = idx_q;
        wrdata_d = wrdata_q;
        write_d  = write_q;
        hold_d   = hold_q;
        done_d   = done_q;
        case (state_q)
            S_LOAD: begin
                wrdata_d = bus.rom_rddata;
                write_d  = 1'b1;
            end
            S_WRITE: begin
                if (accept) begin
                    write_d = 1'b0;
                    idx_d   = idx_q + 10'd1;
                    if (last_byte) begin
                        hold_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.reload) begin
                    idx_d  = 10'd0;
                    hold_d = 1'b1;
                    done_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= 10'd0;
            wrdata_q <= 8'd0;
            write_q  <= 1'b0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            wrdata_q <= wrdata_d;
            write_q  <= write_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       sum_ok_q, sum_ok_d;

    // The status reads 1 throughout a copy and is only judged on DONE entry.
    always_comb begin
        sum_d    = sum_q;
        sum_ok_d = sum_ok_q;
        case (state_q)
            S_LOAD: sum_d = sum_q + bus.rom_rddata;
            S_WRITE: begin
                if (accept && last_byte) begin
                    sum_ok_d = (sum_q == 8'h00);
                end
            end
            S_DONE: begin
                if (bus.reload) begin
                    sum_d    = 8'h00;
                    sum_ok_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= 8'h00;
            sum_ok_q <= 1'b1;
        end else begin
            sum_q    <= sum_d;
            sum_ok_q <= sum_ok_d;
        end
    end

    assign bus.sum_ok = sum_ok_q;
`else
    assign bus.sum_ok = 1'b1;
`endif

    // Addresses follow the byte index directly; RAM address wraps modulo 2^16.
    assign bus.rom_addr   = idx_q[8:0];
    assign bus.ram_addr   = DEST_BASE + {6'd0, idx_q};
    assign bus.ram_wrdata = wrdata_q;
    assign bus.ram_write  = write_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: cycle-exact vector table on a 4-byte wrapping copy,
// plus full 512-byte passes covering stalls, mid-copy reset, reload and the checksum status.
module tb_boot_loader;

`ifdef BOOT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    boot_loader_if ifa ();
    boot_loader_if ifb ();
    boot_loader_if ifc ();

    boot_loader #(.LENGTH(512), .DEST_BASE(16'hFE00)) u_a (.clk(clk), .rst(rst), .bus(ifa.master));
    boot_loader #(.LENGTH(4),   .DEST_BASE(16'hFFFE)) u_b (.clk(clk), .rst(rst), .bus(ifb.master));
    boot_loader #(.LENGTH(1),   .DEST_BASE(16'h1234)) u_c (.clk(clk), .rst(rst), .bus(ifc.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models with a one-cycle synchronous read.
    logic [7:0] rom_a [512];
    always @(posedge clk) ifa.rom_rddata <= rom_a[ifa.rom_addr];
    always @(posedge clk) ifb.rom_rddata <= (ifb.rom_addr < 9'd4) ? (8'hA0 + ifb.rom_addr[7:0]) : 8'h00;
    always @(posedge clk) ifc.rom_rddata <= (ifc.rom_addr == 9'd0) ? 8'h5A : 8'h00;

    // RAM models: record writes that will be accepted on the coming rising edge.
    logic [8:0] ram_a [512];
    int a_writes, a_oob;
    int c_writes;
    logic [15:0] c_addr;
    logic [7:0]  c_data;

    always @(negedge clk) begin
        if (!rst && ifa.ram_write && !ifa.ram_wait) begin
            a_writes++;
            if (ifa.ram_addr[15:9] != 7'h7F) a_oob++;
            else ram_a[ifa.ram_addr[8:0]] = {1'b0, ifa.ram_wrdata};
        end
        if (!rst && ifc.ram_write && !ifc.ram_wait) begin
            c_writes++;
            c_addr = ifc.ram_addr;
            c_data = ifc.ram_wrdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_a();
        for (int i = 0; i < 512; i++) ram_a[i] = 9'h100;
        a_writes = 0;
        a_oob    = 0;
    endtask

    task automatic check_a_image(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < 512; i++) begin
            if (ram_a[i] !== {1'b0, rom_a[i]}) mism++;
        end
        check({tag, "_data_mismatches"}, mism, 0);
        check({tag, "_writes"}, a_writes, 512);
        check({tag, "_out_of_range"}, a_oob, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs instance A to DONE counting edges; optional stall on one byte and optional reset on one byte.
    task automatic run_a(input int stall_byte, input int stall_len, input int rst_byte,
                         output int cycles, output int stall_cycles, output int stall_bad);
        int   stalls;
        bit   did_rst;
        logic prev_hold;
        cycles       = 0;
        stalls       = 0;
        stall_cycles = 0;
        stall_bad    = 0;
        did_rst      = 1'b0;
        prev_hold    = ifa.cpu_hold;
        forever begin
            @(posedge clk); #1;
            cycles++;
            ifa.ram_wait = 1'b0;
            if (stall_len > 0 && ifa.ram_write && ifa.ram_addr == 16'hFE00 + 16'(stall_byte)) begin
                stall_cycles++;
                if (ifa.ram_wrdata !== rom_a[stall_byte]) stall_bad++;
                if (stalls < stall_len) begin
                    ifa.ram_wait = 1'b1;
                    stalls++;
                end
            end
            if (rst_byte >= 0 && !did_rst && ifa.ram_write && ifa.ram_addr == 16'hFE00 + 16'(rst_byte)) begin
                rst = 1'b1;
                #1;
                check("rst_rom_addr", ifa.rom_addr, 9'd0);
                check("rst_ram_addr", ifa.ram_addr, 16'hFE00);
                check("rst_ram_wrdata", ifa.ram_wrdata, 8'h00);
                check("rst_ram_write", ifa.ram_write, 1'b0);
                check("rst_cpu_hold", ifa.cpu_hold, 1'b1);
                check("rst_done", ifa.done, 1'b0);
                check("rst_sum_ok", ifa.sum_ok, 1'b1);
                @(negedge clk);
                rst       = 1'b0;
                did_rst   = 1'b1;
                cycles    = 0;
                a_writes  = 0;
                prev_hold = ifa.cpu_hold;
                continue;
            end
            if (ifa.done) begin
                check("a_hold_before_done", prev_hold, 1'b1);
                check("a_hold_at_done", ifa.cpu_hold, 1'b0);
                break;
            end
            prev_hold = ifa.cpu_hold;
            if (cycles > 3000) begin
                check("a_done_timeout", 0, 1);
                break;
            end
        end
    endtask

    // Cycle-exact vectors for instance B (DEST_BASE=FFFE, LENGTH=4, ROM[i]=A0+i).
    typedef struct {
        logic        reload;
        logic        wt;
        logic [8:0]  rom_addr;
        logic [15:0] ram_addr;
        logic        ram_write;
        logic [7:0]  wrdata;
        logic        hold;
        logic        done;
        logic        sum_ok;
    } vec_t;

    function automatic vec_t mk(logic rl, logic wt, logic [8:0] ra, logic [15:0] wa, logic w,
                                logic [7:0] d, logic h, logic dn, logic s);
        vec_t v;
        v.reload = rl; v.wt = wt; v.rom_addr = ra; v.ram_addr = wa; v.ram_write = w;
        v.wrdata = d; v.hold = h; v.done = dn; v.sum_ok = s;
        return v;
    endfunction

    function automatic logic [63:0] pack_b();
        return {27'd0, ifb.rom_addr, ifb.ram_addr, ifb.ram_write, ifb.ram_wrdata,
                ifb.cpu_hold, ifb.done, ifb.sum_ok};
    endfunction

    function automatic logic [63:0] pack_v(vec_t v);
        return {27'd0, v.rom_addr, v.ram_addr, v.ram_write, v.wrdata, v.hold, v.done, v.sum_ok};
    endfunction

    vec_t vecs [22];

    task automatic run_b_table();
        check("b_reset_state", pack_b(), pack_v(vecs[0]));
        for (int k = 1; k < 22; k++) begin
            ifb.reload   = vecs[k].reload;
            ifb.ram_wait = vecs[k].wt;
            @(posedge clk); #1;
            check($sformatf("b_vec%0d", k), pack_b(), pack_v(vecs[k]));
        end
        ifb.reload   = 1'b0;
        ifb.ram_wait = 1'b0;
    endtask

    int cyc, stc, stb, c_cycles;

    initial begin
        logic bs;
        checks = 0;
        errors = 0;
        bs = CK ? 1'b0 : 1'b1;  // image A0..A3 sums to 86h, not zero

        //            reload wait rom  ram       wr data   hold done sum
        vecs[0]  = mk(0, 0, 9'd0, 16'hFFFE, 0, 8'h00, 1, 0, 1);
        vecs[1]  = mk(0, 0, 9'd0, 16'hFFFE, 0, 8'h00, 1, 0, 1);
        vecs[2]  = mk(0, 0, 9'd0, 16'hFFFE, 1, 8'hA0, 1, 0, 1);
        vecs[3]  = mk(0, 0, 9'd1, 16'hFFFF, 0, 8'hA0, 1, 0, 1);
        vecs[4]  = mk(0, 0, 9'd1, 16'hFFFF, 0, 8'hA0, 1, 0, 1);
        vecs[5]  = mk(0, 0, 9'd1, 16'hFFFF, 1, 8'hA1, 1, 0, 1);
        vecs[6]  = mk(1, 0, 9'd2, 16'h0000, 0, 8'hA1, 1, 0, 1);
        vecs[7]  = mk(0, 0, 9'd2, 16'h0000, 0, 8'hA1, 1, 0, 1);
        vecs[8]  = mk(0, 0, 9'd2, 16'h0000, 1, 8'hA2, 1, 0, 1);
        vecs[9]  = mk(0, 0, 9'd3, 16'h0001, 0, 8'hA2, 1, 0, 1);
        vecs[10] = mk(0, 0, 9'd3, 16'h0001, 0, 8'hA2, 1, 0, 1);
        vecs[11] = mk(0, 0, 9'd3, 16'h0001, 1, 8'hA3, 1, 0, 1);
        vecs[12] = mk(0, 0, 9'd4, 16'h0002, 0, 8'hA3, 0, 1, bs);
        vecs[13] = mk(0, 0, 9'd4, 16'h0002, 0, 8'hA3, 0, 1, bs);
        vecs[14] = mk(1, 0, 9'd0, 16'hFFFE, 0, 8'hA3, 1, 0, 1);
        vecs[15] = mk(0, 1, 9'd0, 16'hFFFE, 0, 8'hA3, 1, 0, 1);
        vecs[16] = mk(0, 1, 9'd0, 16'hFFFE, 1, 8'hA0, 1, 0, 1);
        vecs[17] = mk(0, 1, 9'd0, 16'hFFFE, 1, 8'hA0, 1, 0, 1);
        vecs[18] = mk(0, 1, 9'd0, 16'hFFFE, 1, 8'hA0, 1, 0, 1);
        vecs[19] = mk(0, 0, 9'd1, 16'hFFFF, 0, 8'hA0, 1, 0, 1);
        vecs[20] = mk(0, 0, 9'd1, 16'hFFFF, 0, 8'hA0, 1, 0, 1);
        vecs[21] = mk(0, 0, 9'd1, 16'hFFFF, 1, 8'hA1, 1, 0, 1);

        for (int i = 0; i < 512; i++) rom_a[i] = i[7:0];
        rst = 1'b1;
        ifa.ram_wait = 1'b0; ifa.reload = 1'b0; ifa.rom_rddata = 8'h00;
        ifb.ram_wait = 1'b0; ifb.reload = 1'b0; ifb.rom_rddata = 8'h00;
        ifc.ram_wait = 1'b0; ifc.reload = 1'b0; ifc.rom_rddata = 8'h00;
        c_writes = 0;
        clear_a();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a_reset_rom_addr", ifa.rom_addr, 9'd0);
        check("a_reset_ram_addr", ifa.ram_addr, 16'hFE00);
        check("a_reset_outputs", {ifa.ram_wrdata, ifa.ram_write, ifa.cpu_hold, ifa.done, ifa.sum_ok},
              {8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
        rst = 1'b0;

        // Pass 1: all three instances from reset release.
        fork
            run_b_table();
            run_a(-1, 0, -1, cyc, stc, stb);
            begin
                c_cycles = 0;
                do begin
                    @(posedge clk); #1;
                    c_cycles++;
                end while (!ifc.done && c_cycles < 50);
            end
        join
        check("a_copy_cycles", cyc, 1536);
        check("a_done", ifa.done, 1'b1);
        check("a_sum_ok_zero_image", ifa.sum_ok, 1'b1);
        check_a_image("pass1");
        check("c_done_cycles", c_cycles, 3);
        check("c_writes", c_writes, 1);
        check("c_addr", c_addr, 16'h1234);
        check("c_data", c_data, 8'h5A);
        check("c_sum_ok", ifc.sum_ok, CK ? 1'b0 : 1'b1);

        // Pass 2: five stall cycles on byte 7.
        pulse_reset();
        clear_a();
        run_a(7, 5, -1, cyc, stc, stb);
        check("stall_copy_cycles", cyc, 1541);
        check("stall_write_high_cycles", stc, 6);
        check("stall_data_unstable", stb, 0);
        check_a_image("stall");

        // Pass 3: reset asserted while byte 100 is being written.
        pulse_reset();
        clear_a();
        run_a(-1, 0, 100, cyc, stc, stb);
        check("rst_restart_cycles", cyc, 1536);
        check_a_image("rst_restart");

        // Pass 4: reload in DONE repeats the copy.
        clear_a();
        ifa.reload = 1'b1;
        @(posedge clk); #1;
        ifa.reload = 1'b0;
        check("reload_hold", ifa.cpu_hold, 1'b1);
        check("reload_done_clear", ifa.done, 1'b0);
        check("reload_rom_addr", ifa.rom_addr, 9'd0);
        run_a(-1, 0, -1, cyc, stc, stb);
        check("reload_copy_cycles", cyc, 1536);
        check_a_image("reload");
        check("reload_sum_ok", ifa.sum_ok, 1'b1);

        // Pass 5: unbalanced image (byte 0 = 01h).
        rom_a[0] = 8'h01;
        clear_a();
        ifa.reload = 1'b1;
        @(posedge clk); #1;
        ifa.reload = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bad_image_sum_ok_mid_copy", ifa.sum_ok, 1'b1);
        run_a(-1, 0, -1, cyc, stc, stb);
        check("bad_image_copy_cycles", cyc, 1526);
        check_a_image("bad_image");
        check("bad_image_sum_ok", ifa.sum_ok, CK ? 1'b0 : 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
